register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised successor to the core register file.
- Configurable data width and register count.
- N combinational read ports, two prioritised write ports, optional write-to-read bypass, optional hardwired zero register, synchronous clear.
- Per-register busy scoreboard lets the pipeline stall reads of registers with an in-flight producer.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of registers (power of two, >= 2); AW = clog2(NREG) is a derived localparam
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, and writes/reservations to it are ignored
BYPASS, 1, 1 = a read of an address being written this cycle returns the incoming write data

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
rs  input  NREAD*AW  packed read addresses; port i = rs[i*AW +: AW]
dataOut  output  NREAD*XLEN  packed read data; port i = dataOut[i*XLEN +: XLEN]
busyOut  output  NREAD  busy bit of the register addressed by each read port
we0  input  1  write enable, port 0
rd0  input  AW  write address, port 0
dataIn0  input  XLEN  write data, port 0
we1  input  1  write enable, port 1 (higher priority)
rd1  input  AW  write address, port 1
dataIn1  input  XLEN  write data, port 1
rsv  input  1  reserve: mark rsvRd busy
rsvRd  input  AW  register to reserve

Behaviour:
- Storage: NREG x XLEN registers and an NREG-bit busy vector.
- Reset: while RST is high at a rising edge, all registers clear to 0 and all busy bits clear.
  - RST overrides every write and reserve in the same cycle.
  - dataOut and busyOut are combinational from state, so they read 0 in the cycle after reset.
- Read:
  - Combinational, zero latency.
  - With ZERO_REG=1, address 0 returns 0 and busyOut=0 regardless of state or bypass.
- Write:
  - Takes effect at the rising edge; stored data is visible to a non-bypassed read in the next cycle.
  - we0 and we1 are independent when rd0 != rd1.
  - When we0 and we1 are both set with rd0 == rd1, port 1 data is stored.
- Bypass:
  - With BYPASS=1, a read address matching an active write address returns that write's dataIn in the same cycle.
  - If both write ports match, port 1 wins.
  - With BYPASS=0, the read returns the stored (old) value until after the edge.
- Scoreboard:
  - A write to register r clears busy[r] at the edge.
  - rsv sets busy[rsvRd] at the edge.
  - If a write and rsv target the same register in the same cycle, busy ends set: reserve wins, because a new producer is in flight.
  - With ZERO_REG=1, writes and reservations to register 0 are ignored.
- busyOut bypass:
  - busyOut reflects stored busy bits only; there is no same-cycle bypass of rsv.
  - When BYPASS=1 and an active write matches the read address, busyOut for that port is 0, since the data is valid via bypass.
- Multiple read ports may address the same register; each returns identical data and busy.
- Out-of-range addresses cannot occur because NREG is a power of two.
- RTL must be synthesisable with a for-loop over read ports; no latches.

Test Plan:
- Reset/clear: write 0xDEADBEEF to r5, then assert RST for 1 cycle -> r5 reads 0x00000000, busyOut=0 on all ports.
- Basic write/read: we0=1, rd0=3, dataIn0=0x12345678, with rs port0=3.
  - BYPASS=0: port0 reads old value 0, then 0x12345678 the next cycle.
  - BYPASS=1: port0 reads 0x12345678 in the same cycle.
- Write collision: we0=we1=1, rd0=rd1=7, dataIn0=0xAAAA0000, dataIn1=0x5555FFFF -> r7 stores 0x5555FFFF; the same-cycle bypass read of r7 also shows 0x5555FFFF.
- Zero register (ZERO_REG=1): we1=1, rd1=0, dataIn1=0xFFFFFFFF and rsv=1, rsvRd=0 -> reading r0 on all NREAD ports gives 0 and busyOut=0 in that and every later cycle.
- Scoreboard:
  - rsv on r9 -> busyOut=1 for a port reading r9 the next cycle.
  - we0 to r9 with 0x00000042 -> busyOut=0 that cycle (bypass) and the following cycle; data reads 0x00000042.
  - Simultaneous rsv r9 and we0 r9 -> busy stays 1 after the edge.
- Reset mid-operation: assert RST in the same cycle as we0 to r2 (0x11111111) and rsv r4 -> after the edge, r2=0 and busy[4]=0.
- Parameter sweep: XLEN=64, NREG=16, NREAD=3 -> random writes checked against a reference model for 10k cycles with zero mismatches.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file: NREAD combinational read ports, two prioritised write
// ports, optional write-to-read bypass, optional hardwired zero register, busy scoreboard.
module register_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREAD*AW-1:0]     rs,
    output logic [NREAD*XLEN-1:0]   dataOut,
    output logic [NREAD-1:0]        busyOut,
    input  logic                    we0,
    input  logic [AW-1:0]           rd0,
    input  logic [XLEN-1:0]         dataIn0,
    input  logic                    we1,
    input  logic [AW-1:0]           rd1,
    input  logic [XLEN-1:0]         dataIn1,
    input  logic                    rsv,
    input  logic [AW-1:0]           rsvRd
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    logic wen0;
    logic wen1;
    logic rsv_en;

    // Accesses aimed at a hardwired zero register are dropped before they reach state.
    assign wen0   = we0 && !((ZERO_REG != 0) && (rd0 == '0));
    assign wen1   = we1 && !((ZERO_REG != 0) && (rd1 == '0));
    assign rsv_en = rsv && !((ZERO_REG != 0) && (rsvRd == '0));

    // Port 1 is applied after port 0 so it wins a same-address collision;
    // the reservation is applied last so a new producer keeps the register busy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            if (wen0) begin
                regs[rd0] <= dataIn0;
                busy[rd0] <= 1'b0;
            end
            if (wen1) begin
                regs[rd1] <= dataIn1;
                busy[rd1] <= 1'b0;
            end
            if (rsv_en) begin
                busy[rsvRd] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rs[i*AW +: AW];

        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
            if (BYPASS != 0) begin
                if (wen0 && (rd0 == addr)) begin
                    data = dataIn0;
                    bsy  = 1'b0;
                end
                if (wen1 && (rd1 == addr)) begin
                    data = dataIn1;
                    bsy  = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign dataOut[i*XLEN +: XLEN] = data;
        assign busyOut[i]              = bsy;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed and randomised bench for register_file_mp: a bypassing 32x32 instance
// and a non-bypassing 16x64, three-read-port instance without a zero register.
module tb_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (XLEN=32, NREG=32, NREAD=2, ZERO_REG=1, BYPASS=1)
    logic        a_rst;
    logic [9:0]  a_rs;
    logic [63:0] a_dout;
    logic [1:0]  a_bout;
    logic        a_we0, a_we1, a_rsv;
    logic [4:0]  a_rd0, a_rd1, a_rsvrd;
    logic [31:0] a_din0, a_din1;

    register_file_mp dut_a (
        .CLK(clk), .RST(a_rst), .rs(a_rs), .dataOut(a_dout), .busyOut(a_bout),
        .we0(a_we0), .rd0(a_rd0), .dataIn0(a_din0),
        .we1(a_we1), .rd1(a_rd1), .dataIn1(a_din1),
        .rsv(a_rsv), .rsvRd(a_rsvrd)
    );

    // Instance B: XLEN=64, NREG=16, NREAD=3, no zero register, no bypass
    logic         b_rst;
    logic [11:0]  b_rs;
    logic [191:0] b_dout;
    logic [2:0]   b_bout;
    logic         b_we0, b_we1, b_rsv;
    logic [3:0]   b_rd0, b_rd1, b_rsvrd;
    logic [63:0]  b_din0, b_din1;

    register_file_mp #(.XLEN(64), .NREG(16), .NREAD(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .CLK(clk), .RST(b_rst), .rs(b_rs), .dataOut(b_dout), .busyOut(b_bout),
        .we0(b_we0), .rd0(b_rd0), .dataIn0(b_din0),
        .we1(b_we1), .rd1(b_rd1), .dataIn1(b_din1),
        .rsv(b_rsv), .rsvRd(b_rsvrd)
    );

    typedef struct {
        string       tag;
        bit          on_b;
        int          port;
        logic [63:0] data;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [63:0] ref_mem  [16];
    logic [15:0] ref_busy;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string tag, input bit on_b, input int port,
                             input logic [63:0] d, input logic b);
        exp_t e;
        e.tag = tag; e.on_b = on_b; e.port = port; e.data = d; e.busy = b;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [63:0] od;
        logic        ob;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.on_b) begin
                od = b_dout[e.port*64 +: 64];
                ob = b_bout[e.port];
            end else begin
                od = {32'b0, a_dout[e.port*32 +: 32]};
                ob = a_bout[e.port];
            end
            checks++;
            assert (od === e.data) else begin
                failures++;
                $error("FAIL %s.data[%0d] observed=%h expected=%h", e.tag, e.port, od, e.data);
            end
            checks++;
            assert (ob === e.busy) else begin
                failures++;
                $error("FAIL %s.busy[%0d] observed=%b expected=%b", e.tag, e.port, ob, e.busy);
            end
        end
    endtask

    task automatic a_idle();
        a_we0 = 0; a_we1 = 0; a_rsv = 0;
    endtask

    initial begin
        a_rst = 1; a_rs = '0; a_we0 = 0; a_we1 = 0; a_rsv = 0;
        a_rd0 = '0; a_rd1 = '0; a_rsvrd = '0; a_din0 = '0; a_din1 = '0;
        b_rst = 1; b_rs = '0; b_we0 = 0; b_we1 = 0; b_rsv = 0;
        b_rd0 = '0; b_rd1 = '0; b_rsvrd = '0; b_din0 = '0; b_din1 = '0;
        tick(); tick();
        a_rst = 0; b_rst = 0;

        // Reset state
        a_rs = {5'd0, 5'd5};
        expect_rd("reset", 0, 0, 64'h0, 1'b0);
        expect_rd("reset", 0, 1, 64'h0, 1'b0);
        check_all();

        // Write r5 then clear it with RST
        a_we0 = 1; a_rd0 = 5'd5; a_din0 = 32'hDEADBEEF;
        tick(); a_idle();
        a_rs = {5'd5, 5'd5};
        expect_rd("pre_clear", 0, 0, 64'hDEADBEEF, 1'b0);
        check_all();
        a_rst = 1; tick(); a_rst = 0;
        expect_rd("clear", 0, 0, 64'h0, 1'b0);
        expect_rd("clear", 0, 1, 64'h0, 1'b0);
        check_all();

        // Basic write with same-cycle bypass
        a_we0 = 1; a_rd0 = 5'd3; a_din0 = 32'h12345678; a_rs = {5'd0, 5'd3};
        expect_rd("bypass", 0, 0, 64'h12345678, 1'b0);
        check_all();
        tick(); a_idle();
        expect_rd("stored", 0, 0, 64'h12345678, 1'b0);
        check_all();

        // Write collision: port 1 wins both in bypass and in storage
        a_we0 = 1; a_rd0 = 5'd7; a_din0 = 32'hAAAA0000;
        a_we1 = 1; a_rd1 = 5'd7; a_din1 = 32'h5555FFFF;
        a_rs = {5'd7, 5'd7};
        expect_rd("coll_byp", 0, 0, 64'h5555FFFF, 1'b0);
        expect_rd("coll_byp", 0, 1, 64'h5555FFFF, 1'b0);
        check_all();
        tick(); a_idle();
        expect_rd("coll_st", 0, 1, 64'h5555FFFF, 1'b0);
        check_all();

        // Zero register ignores writes and reservations
        a_we1 = 1; a_rd1 = 5'd0; a_din1 = 32'hFFFFFFFF; a_rsv = 1; a_rsvrd = 5'd0;
        a_rs = {5'd0, 5'd0};
        expect_rd("zero_same", 0, 0, 64'h0, 1'b0);
        expect_rd("zero_same", 0, 1, 64'h0, 1'b0);
        check_all();
        tick(); a_idle();
        for (int k = 0; k < 2; k++) begin
            expect_rd("zero_after", 0, 0, 64'h0, 1'b0);
            expect_rd("zero_after", 0, 1, 64'h0, 1'b0);
            check_all();
            tick();
        end

        // Scoreboard: reserve r9, no same-cycle busy bypass
        a_rsv = 1; a_rsvrd = 5'd9; a_rs = {5'd0, 5'd9};
        expect_rd("rsv_same", 0, 0, 64'h0, 1'b0);
        check_all();
        tick(); a_idle();
        expect_rd("rsv_next", 0, 0, 64'h0, 1'b1);
        check_all();
        a_we0 = 1; a_rd0 = 5'd9; a_din0 = 32'h00000042;
        expect_rd("wr_busy_byp", 0, 0, 64'h42, 1'b0);
        check_all();
        tick(); a_idle();
        expect_rd("wr_busy_st", 0, 0, 64'h42, 1'b0);
        check_all();
        a_we0 = 1; a_rd0 = 5'd9; a_din0 = 32'h00000077; a_rsv = 1; a_rsvrd = 5'd9;
        expect_rd("rsv_wr_same", 0, 0, 64'h77, 1'b0);
        check_all();
        tick(); a_idle();
        expect_rd("rsv_wr_next", 0, 0, 64'h77, 1'b1);
        check_all();

        // Reset overrides a same-cycle write and reserve
        a_we0 = 1; a_rd0 = 5'd2; a_din0 = 32'h11111111; a_rsv = 1; a_rsvrd = 5'd4;
        a_rst = 1;
        tick(); a_idle(); a_rst = 0;
        a_rs = {5'd4, 5'd2};
        expect_rd("rst_mid", 0, 0, 64'h0, 1'b0);
        expect_rd("rst_mid", 0, 1, 64'h0, 1'b0);
        check_all();
        a_rs = {5'd9, 5'd2};
        expect_rd("rst_mid_r9", 0, 1, 64'h0, 1'b0);
        check_all();

        // Instance B: without bypass the old value is seen until the edge
        b_we0 = 1; b_rd0 = 4'd3; b_din0 = 64'h12345678; b_rs = {4'd0, 4'd0, 4'd3};
        expect_rd("nobyp_old", 1, 0, 64'h0, 1'b0);
        check_all();
        tick(); b_we0 = 0;
        expect_rd("nobyp_new", 1, 0, 64'h12345678, 1'b0);
        check_all();

        // Randomised sweep against a reference model
        b_rst = 1; tick(); b_rst = 0;
        for (int r = 0; r < 16; r++) ref_mem[r] = '0;
        ref_busy = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            b_rst   = ($urandom_range(0, 199) == 0);
            b_we0   = $urandom_range(0, 1);
            b_rd0   = 4'($urandom_range(0, 15));
            b_din0  = {$urandom, $urandom};
            b_we1   = $urandom_range(0, 1);
            b_rd1   = 4'($urandom_range(0, 15));
            b_din1  = {$urandom, $urandom};
            b_rsv   = ($urandom_range(0, 2) == 0);
            b_rsvrd = 4'($urandom_range(0, 15));
            for (int p = 0; p < 3; p++) begin
                b_rs[p*4 +: 4] = 4'($urandom_range(0, 15));
                expect_rd("sweep", 1, p, ref_mem[b_rs[p*4 +: 4]], ref_busy[b_rs[p*4 +: 4]]);
            end
            check_all();
            if (b_rst) begin
                for (int r = 0; r < 16; r++) ref_mem[r] = '0;
                ref_busy = '0;
            end else begin
                if (b_we0) begin ref_mem[b_rd0] = b_din0; ref_busy[b_rd0] = 1'b0; end
                if (b_we1) begin ref_mem[b_rd1] = b_din1; ref_busy[b_rd1] = 1'b0; end
                if (b_rsv) ref_busy[b_rsvrd] = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
